// File: rtl/writeback_unit_pkg.sv
// Shared types for the RV32I writeback path: result sources, load funct3 codes, writeback FSM states.
// Consumed by writeback_unit, its interface and load_aligner via import rv32i_pkg::*.
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2,
        WB_SRC_IMM = 2'd3
    } wb_src_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback request, load-return and register-file write port bundle.
// slave = writeback_unit side, master = controller/memory/register-file side.
interface writeback_unit_if;
    import rv32i_pkg::*;

    logic        wb_valid;
    logic        wb_ready;
    wb_src_e     wb_src;
    logic [4:0]  wb_rd;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        write_register;
    logic [4:0]  rd;
    logic [31:0] rdv;
    logic        wb_done;
    logic        wb_err;

    modport slave (
        input  wb_valid, wb_src, wb_rd, funct3, alu_result, pc, imm, mem_rdata, mem_rvalid,
        output wb_ready, write_register, rd, rdv, wb_done, wb_err
    );

    modport master (
        output wb_valid, wb_src, wb_rd, funct3, alu_result, pc, imm, mem_rdata, mem_rvalid,
        input  wb_ready, write_register, rd, rdv, wb_done, wb_err
    );

endinterface

// File: rtl/writeback_unit_load_aligner.sv
// Combinational load aligner: picks byte/halfword/word by address offset and extends it.
// Also flags misaligned halfword/word accesses and reserved funct3 codes.
module load_aligner
    import rv32i_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        value      = 32'd0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU: value = {24'd0, byte_sel};
            F3_LH: begin
                value      = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            F3_LHU: begin
                value      = {16'd0, half_sel};
                misaligned = offset[0];
            end
            F3_LW: begin
                value      = word;
                misaligned = (offset != 2'd0);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writer for the RV32I multi-cycle core: source select, load wait/align, one-cycle write.
// Optional WAIT_MEM timeout is enabled by defining WB_TIMEOUT_EN.
//
// state       | meaning
// ST_IDLE     | ready for a request; accepts on wb_valid
// ST_WAIT_MEM | load accepted, waiting for mem_rvalid (or timeout)
// ST_WRITE    | one cycle: write port / wb_done / wb_err outputs asserted
module writeback_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    writeback_unit_if.slave bus
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("writeback_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    wb_state_e   state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [1:0]  aln_offset;
    logic [2:0]  aln_funct3;
    logic [31:0] aln_value;
    logic        aln_misaligned;
    logic [31:0] src_value;

`ifdef WB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt;
`endif

    // One aligner serves both the accept-time misalignment check and the later data alignment.
    assign aln_offset = (state == ST_IDLE) ? bus.alu_result[1:0] : off_q;
    assign aln_funct3 = (state == ST_IDLE) ? bus.funct3 : f3_q;

    load_aligner u_aligner (
        .word       (bus.mem_rdata),
        .offset     (aln_offset),
        .funct3     (aln_funct3),
        .value      (aln_value),
        .misaligned (aln_misaligned)
    );

    always_comb begin
        src_value = bus.alu_result;
        case (bus.wb_src)
            WB_SRC_ALU: src_value = bus.alu_result;
            WB_SRC_PC4: src_value = bus.pc + 32'd4;
            WB_SRC_IMM: src_value = bus.imm;
            default:    src_value = bus.alu_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            f3_q               <= 3'd0;
            off_q              <= 2'd0;
            bus.wb_ready       <= 1'b1;
            bus.write_register <= 1'b0;
            bus.wb_done        <= 1'b0;
            bus.wb_err         <= 1'b0;
            bus.rd             <= 5'd0;
            bus.rdv            <= 32'd0;
`ifdef WB_TIMEOUT_EN
            tmo_cnt            <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.wb_valid) begin
                        bus.rd       <= bus.wb_rd;
                        f3_q         <= bus.funct3;
                        off_q        <= bus.alu_result[1:0];
                        bus.wb_ready <= 1'b0;
                        if (bus.wb_src != WB_SRC_MEM) begin
                            bus.rdv            <= src_value;
                            bus.write_register <= (bus.wb_rd != 5'd0);
                            bus.wb_done        <= 1'b1;
                            state              <= ST_WRITE;
                        end else if (aln_misaligned) begin
                            bus.rdv     <= 32'd0;
                            bus.wb_err  <= 1'b1;
                            bus.wb_done <= 1'b1;
                            state       <= ST_WRITE;
                        end else begin
`ifdef WB_TIMEOUT_EN
                            tmo_cnt <= 8'd0;
`endif
                            state   <= ST_WAIT_MEM;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        bus.rdv            <= aln_value;
                        bus.write_register <= (bus.rd != 5'd0);
                        bus.wb_done        <= 1'b1;
                        state              <= ST_WRITE;
                    end
`ifdef WB_TIMEOUT_EN
                    else if (tmo_cnt + 8'd1 == TMO_LIMIT) begin
                        bus.wb_err  <= 1'b1;
                        bus.wb_done <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                ST_WRITE: begin
                    bus.write_register <= 1'b0;
                    bus.wb_done        <= 1'b0;
                    bus.wb_err         <= 1'b0;
                    bus.wb_ready       <= 1'b1;
                    state              <= ST_IDLE;
                end
                default: begin
                    bus.write_register <= 1'b0;
                    bus.wb_done        <= 1'b0;
                    bus.wb_err         <= 1'b0;
                    bus.wb_ready       <= 1'b1;
                    state              <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Register-file writer for the RV32I multi-cycle core. Accepts one writeback request per instruction from the control FSM, selects the result source, waits for load data from memory when required, aligns and sign/zero-extends loads, and drives the register file's write port for exactly one cycle. It is the producing end of the register-file write interface (`write_register`, `rd`, `rdv`).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 16: maximum cycles spent in WAIT_MEM before error. Used only with `WB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  core clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `wb_valid`  in  1  writeback request present.
- `wb_ready`  out  1  unit can accept a request (high only in IDLE).
- `wb_src`  in  2  result source: ALU=0, MEM=1, PC4=2, IMM=3.
- `wb_rd`  in  5  destination register.
- `funct3`  in  3  load width/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5).
- `alu_result`  in  32  ALU result; byte address for loads.
- `pc`  in  32  instruction PC.
- `imm`  in  32  immediate (LUI).
- `mem_rdata`  in  32  word read from memory.
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle.
- `write_register`  out  1  register-file write enable.
- `rd`  out  5  register-file write index.
- `rdv`  out  32  register-file write data.
- `wb_done`  out  1  one-cycle pulse: writeback finished (write or suppressed).
- `wb_err`  out  1  one-cycle pulse: misaligned load or timeout; no write.

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- IDLE: `wb_ready`=1. On `wb_valid`: latch `wb_rd`, `funct3`, `alu_result[1:0]`, source operand. MEM → WAIT_MEM; otherwise compute value → WRITE.
- Source values: ALU → `alu_result`; PC4 → `pc + 4` (mod 2^32); IMM → `imm`.
- WAIT_MEM: on `mem_rvalid`, capture aligned load value → WRITE. `mem_rvalid` in any other state is ignored.
- Load alignment, offset `a = addr[1:0]`: LB/LBU select byte `a`; LH/LHU select halfword `a[1]`; LW full word. LB/LH sign-extend, LBU/LHU zero-extend.
- Misalignment (checked at accept): LH/LHU with `a[0]`=1, LW with `a`≠0, or reserved `funct3` (3, 6, 7) → skip WAIT_MEM, go to WRITE with error flag; in WRITE `wb_err`=1, `wb_done`=1, `write_register`=0.
- WRITE (one cycle): `rd`/`rdv` driven from latched values; `write_register`=1 unless `rd`=0 or error flag set; `wb_done`=1; → IDLE.
- `rd`=0: `write_register` stays 0, `wb_done` still pulses, `rdv` still shows computed value.

## Timing
- Reset (synchronous, `rst_n`=0 at posedge): state IDLE; `write_register`, `wb_done`, `wb_err` = 0; `rd` = 0; `rdv` = 0; error flag and timeout counter cleared. `wb_ready` = 1 on the cycle after reset deasserts. Reset during WAIT_MEM drops the pending load; later `mem_rvalid` ignored.
- Non-load: accept at edge N, WRITE during cycle N+1 (`write_register`, `wb_done` high), `wb_ready` high again from N+2.
- Load: `mem_rvalid` sampled at edge M → WRITE during cycle M+1. `mem_rvalid` coincident with the accept edge does not count; data must arrive while in WAIT_MEM.
- Outputs are registered; `rd`/`rdv` are stable for the whole WRITE cycle.
- `wb_valid` while `wb_ready`=0 is ignored; the controller must hold it until accepted.

## Configuration
- `WB_TIMEOUT_EN` defined: 8-bit counter cleared on entry to WAIT_MEM, increments each WAIT_MEM cycle without `mem_rvalid`; reaching `TIMEOUT_CYCLES` → WRITE with error flag (`wb_err`, `wb_done` pulse, no write). `mem_rvalid` on the same edge as the count reaching the limit wins (normal write).
- Not defined: no counter; WAIT_MEM waits indefinitely; `wb_err` only from misalignment.

## Structure
- `rv32i_pkg`: `wb_src_e` enum, load `funct3` constants, `wb_state_e` enum.
- Sub-module `load_aligner`: combinational; inputs word, offset, `funct3`; outputs aligned value and misaligned flag. FSM, latches, and timeout live in `writeback_unit`.

## Test plan
- ALU src, `wb_rd`=5, `alu_result`=0xDEADBEEF → one cycle later `write_register`=1, `rd`=5, `rdv`=0xDEADBEEF, `wb_done`=1.
- PC4 src, `pc`=0xFFFFFFFC, `wb_rd`=1 → `rdv`=0x00000000 (wrap).
- LB, addr 0x1003, `mem_rdata`=0x80112233 after 3 cycles → `rdv`=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x1002 → 0x00008011.
- LW addr 0x1001 → no WAIT_MEM, `wb_err`=1, `wb_done`=1, `write_register`=0; `wb_rd`=0 with ALU src → `wb_done`=1, `write_register`=0.
- Reset asserted in WAIT_MEM, then `mem_rvalid` pulse → no write, `wb_ready`=1, all outputs 0.
- With `WB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no `mem_rvalid` → `wb_err` pulse after 4 WAIT_MEM cycles, no write.
